otter_fetch_queue: RTL
======================

// Module: otter_fetch_queue
// PURPOSE
//  Instruction prefetch queue that feeds the IF/DE pipeline register of the pipelined OTTER CPU.
//  Issues sequential instruction-memory reads and buffers up to DEPTH {pc, ir} pairs.
//  Presents the oldest pair to decode through a valid/ready handshake.
//  Redirects fetch on taken branch/jump (REDIRECT) and discards in-flight responses from the wrong path.
// PARAMETERS
//  DEPTH            4             queue entries (power of 2, >= 2)
//  MAX_OUTSTANDING  2             max accepted IMEM requests without a response (>= 1)
//  RESET_PC         32'h00000000  first fetch address after reset
// PORTS
//  CLK          in   1   clock, all state on rising edge
//  RESET        in   1   asynchronous, active-low reset
//  REDIRECT     in   1   flush queue, restart fetch at REDIRECT_PC
//  REDIRECT_PC  in   32  new fetch address, sampled when REDIRECT=1
//  IMEM_REQ     out  1   read request
//  IMEM_ADDR    out  32  read address (word aligned)
//  IMEM_RDY     in   1   memory accepts request this cycle (accept = IMEM_REQ & IMEM_RDY)
//  IMEM_VALID   in   1   read data valid; responses return in request order, no backpressure
//  IMEM_DATA    in   32  instruction word
//  FQ_VALID     out  1   head entry valid
//  FQ_PC        out  32  head entry pc
//  FQ_IR        out  32  head entry instruction
//  FQ_READY     in   1   decode consumes head (pop = FQ_VALID & FQ_READY)
//  FQ_COUNT     out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset (RESET=0, async): fetch_pc=RESET_PC, queue empty, P=0, D=0; FQ_VALID=0, FQ_PC=0, FQ_IR=0,
//   FQ_COUNT=0, IMEM_REQ=0, IMEM_ADDR=RESET_PC.
//  State: fetch_pc; circular queue (rd/wr ptrs, count); tag FIFO of MAX_OUTSTANDING accepted addresses;
//   P = in-flight requests (incl. to-be-dropped); D = in-flight to drop (D <= P).
//  IMEM_REQ = ~REDIRECT & (P < MAX_OUTSTANDING) & (count + P < DEPTH); IMEM_ADDR = fetch_pc.
//   This reservation guarantees every response has a free slot; the queue cannot overflow.
//  Once asserted, IMEM_REQ/IMEM_ADDR hold stable until accepted; only REDIRECT may withdraw them.
//  Accept: push fetch_pc to tag FIFO, P++, fetch_pc += 4 (mod 2^32: 0xFFFFFFFC -> 0x00000000).
//  Response (IMEM_VALID): pop tag FIFO, P--; if D>0 discard and D--, else push {tag, IMEM_DATA} to queue.
//  Accept and response in the same cycle: P unchanged, both FIFOs updated.
//  IMEM_VALID with P=0: protocol error; ignored, flagged by simulation assertion.
//  FQ_VALID = (count != 0); FQ_PC/FQ_IR = head entry, from registered state only (no IMEM bypass).
//  Response at cycle N -> visible at head no earlier than cycle N+1.
//  Push and pop in the same cycle: count unchanged. Pop with empty queue impossible (FQ_VALID=0).
//  REDIRECT in cycle N (overrides all else): at N+1 queue empty (count=0, FQ_VALID=0),
//   fetch_pc=REDIRECT_PC, D = P minus any response received in N (all in-flight dropped).
//   No accept in cycle N (IMEM_REQ=0). A pop in N is allowed and harmless.
//   A response in N is consumed from the tag FIFO and discarded.
//  Redirect latency, 1-cycle memory: REDIRECT at N, request at N+1, response N+2, FQ_VALID at N+3.
//  Back-to-back REDIRECT: the last one wins; D accumulates correctly because it tracks P.
//  REDIRECT_PC[1:0] != 0: bits forced to 0 in fetch_pc; assertion fires.
//  Reset asserted mid-operation: all state cleared immediately. Responses arriving after release
//   with P=0 are ignored (see protocol error above).
// TESTING
//  1. Reset release, 1-cycle mem, RDY=1, FQ_READY=1 -> IMEM_ADDR 0,4,8..; first FQ_VALID cycle 2;
//     then one pop/cycle, FQ_PC 0,4,8.. and FQ_IR = memory words.
//  2. FQ_READY=0 -> FQ_COUNT rises to 4, IMEM_REQ drops once count+P=4, no lost/duplicate entry;
//     FQ_READY=1 -> drains in order, fetch resumes.
//  3. Two requests in flight (0x10, 0x14), REDIRECT with REDIRECT_PC=0x100 -> both responses dropped;
//     next FQ_PC=0x100 at N+3; then 0x104.
//  4. IMEM_RDY=0 for 3 cycles with IMEM_REQ=1 -> REQ and ADDR stable all 3 cycles, single accept on RDY=1.
//  5. REDIRECT_PC=0xFFFFFFF8 -> FQ_PC sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
//  6. RESET=0 mid-stream with a response arriving the same cycle -> outputs reset values at once, no push;
//     after release, first IMEM_ADDR=RESET_PC.

Source files
------------

// File: rtl/otter_fetch_queue.sv
// Instruction prefetch queue for the pipelined OTTER CPU: issues sequential IMEM reads, buffers
// {pc, ir} pairs for decode, and on REDIRECT flushes and drops wrong-path responses.
module otter_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       REDIRECT,
    input  logic [31:0]                REDIRECT_PC,
    output logic                       IMEM_REQ,
    output logic [31:0]                IMEM_ADDR,
    input  logic                       IMEM_RDY,
    input  logic                       IMEM_VALID,
    input  logic [31:0]                IMEM_DATA,
    output logic                       FQ_VALID,
    output logic [31:0]                FQ_PC,
    output logic [31:0]                FQ_IR,
    input  logic                       FQ_READY,
    output logic [$clog2(DEPTH+1)-1:0] FQ_COUNT
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [PW-1:0] p_q, p_d, d_q, d_d;

    logic [31:0] pc_mem  [DEPTH];
    logic [31:0] ir_mem  [DEPTH];
    logic [31:0] tag_mem [MAX_OUTSTANDING];

    logic accept, resp, push, pop;

    always_comb begin
        // Reserve a queue slot per outstanding request so a response always has room.
        IMEM_REQ  = RESET & ~REDIRECT & (p_q < PW'(MAX_OUTSTANDING))
                    & ((32'(count_q) + 32'(p_q)) < DEPTH);
        IMEM_ADDR = fetch_pc_q;
        FQ_VALID  = (count_q != '0);
        FQ_PC     = FQ_VALID ? pc_mem[rd_ptr_q] : '0;
        FQ_IR     = FQ_VALID ? ir_mem[rd_ptr_q] : '0;
        FQ_COUNT  = count_q;

        accept = IMEM_REQ & IMEM_RDY;
        resp   = IMEM_VALID & (p_q != '0);
        push   = resp & ~REDIRECT & (d_q == '0);
        pop    = FQ_VALID & FQ_READY;

        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        d_d        = d_q;
        p_d        = p_q + PW'(accept) - PW'(resp);

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + 1'b1;
        end
        if (resp) begin
            tag_rd_d = (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + 1'b1;
        end

        if (REDIRECT) begin
            fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight after this cycle belongs to the wrong path.
            d_d        = p_q - PW'(resp);
        end else begin
            if (resp && (d_q != '0)) begin
                d_d = d_q - 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            p_q        <= '0;
            d_q        <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            p_q        <= p_d;
            d_q        <= d_d;
        end
    end

    // Storage arrays need no reset: the head is masked while the queue is empty.
    always_ff @(posedge CLK) begin
        if (accept) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            pc_mem[wr_ptr_q] <= tag_mem[tag_rd_q];
            ir_mem[wr_ptr_q] <= IMEM_DATA;
        end
    end

    a_no_orphan_resp: assert property (@(posedge CLK) disable iff (!RESET)
        IMEM_VALID |-> (p_q != '0));
    a_redirect_aligned: assert property (@(posedge CLK) disable iff (!RESET)
        REDIRECT |-> (REDIRECT_PC[1:0] == 2'b00));
    a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET)
        push |-> ((32'(count_q) < DEPTH) || pop));

endmodule
